// File: rtl/sobel_mem_responder_if.sv
// -----------------------------------------------------------------------------
// sobel_mem_responder_if
// Bundle between the Sobel read/write controller (master) and the memory-side
// responder (slave).
//   instruction : 2-bit opcode, 00 idle, 01 read, 10 write, 11 illegal
//   addr_r      : read address, sampled when the access is accepted
//   addr_w      : write address, sampled when the access is accepted
//   data_w      : write data, sampled when the access is accepted
//   busy        : access in progress; instructions are dropped while high
//   data_r      : last completed read data
//   err         : one-cycle pulse on completion of an out-of-range/illegal access
// -----------------------------------------------------------------------------
interface sobel_mem_responder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [1:0]        instruction;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] addr_w;
  logic [DATA_W-1:0] data_w;
  logic              busy;
  logic [DATA_W-1:0] data_r;
  logic              err;

  modport master (
    output instruction, addr_r, addr_w, data_w,
    input  busy, data_r, err
  );

  modport slave (
    input  instruction, addr_r, addr_w, data_w,
    output busy, data_r, err
  );
endinterface

// File: rtl/sobel_mem_responder.sv
// -----------------------------------------------------------------------------
// sobel_mem_responder
// Memory-side responder standing in for the image SRAM. An accepted access
// holds busy for a fixed latency, then completes against an internal pixel
// RAM: reads update data_r, writes update the RAM, and out-of-range or illegal
// accesses pulse err.
//   clk : single clock, rising edge
//   rst : synchronous, active-high reset (RAM contents are kept)
//   bus : slave side of sobel_mem_responder_if
// Parameters: ADDR_W/DATA_W bus widths, DEPTH RAM words, RD_LAT/WR_LAT busy
// cycles per read/write (each >= 1). Illegal instructions are busy 1 cycle.
// -----------------------------------------------------------------------------
module sobel_mem_responder #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4096,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  sobel_mem_responder_if.slave  bus
);

  localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_MAX = (RD_LAT > WR_LAT) ? RD_LAT : WR_LAT;
  // The counter holds latency-1, so CNT_MAX-1 is the largest value stored.
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_FAULT
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_r_q;
  logic [ADDR_W-1:0] addr_w_q;
  logic [DATA_W-1:0] data_w_q;
  logic              busy_q;
  logic [DATA_W-1:0] data_r_q;
  logic              err_q;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rd_word;
  logic              rd_in_range;
  logic              wr_in_range;
  logic              done;
  logic              mem_we;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 64'(a) < 64'(DEPTH);
  endfunction

  assign rd_in_range = in_range(addr_r_q);
  assign wr_in_range = in_range(addr_w_q);
  assign rd_word     = mem[addr_r_q[IDX_W-1:0]];

  // The edge on which an in-flight access completes.
  assign done   = (state_q != ST_IDLE) && (cnt_q == '0);
  // rst dominates so a write completing on a reset edge is discarded.
  assign mem_we = done && (state_q == ST_WRITE) && wr_in_range && !rst;

  // NOTE: the RAM has no reset branch on purpose; its contents survive rst and
  // a reset-free array maps onto plain SRAM/block RAM instead of flops.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_w_q[IDX_W-1:0]] <= data_w_q;
    end
  end

  // NOTE: every register below uses <= so all state updates on an edge see
  // the pre-edge values; blocking = here would create ordering-dependent logic.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      addr_r_q <= '0;
      addr_w_q <= '0;
      data_w_q <= '0;
      busy_q   <= 1'b0;
      data_r_q <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!busy_q && bus.instruction != 2'b00) begin
            addr_r_q <= bus.addr_r;
            addr_w_q <= bus.addr_w;
            data_w_q <= bus.data_w;
            busy_q   <= 1'b1;
            case (bus.instruction)
              2'b01: begin
                state_q <= ST_READ;
                cnt_q   <= RD_LOAD;
              end
              2'b10: begin
                state_q <= ST_WRITE;
                cnt_q   <= WR_LOAD;
              end
              default: begin
                state_q <= ST_FAULT;
                cnt_q   <= '0;
              end
            endcase
          end
        end
        default: begin
          if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            case (state_q)
              ST_READ: begin
                if (rd_in_range) begin
                  data_r_q <= rd_word;
                end else begin
                  data_r_q <= '0;
                  err_q    <= 1'b1;
                end
              end
              ST_WRITE: begin
                // The RAM update itself happens in the array block via mem_we.
                if (!wr_in_range) begin
                  err_q <= 1'b1;
                end
              end
              default: begin
                err_q <= 1'b1;
              end
            endcase
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.data_r = data_r_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_sobel_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_sobel_mem_responder
// Directed bench for sobel_mem_responder. Instance A uses RD_LAT=2/WR_LAT=1,
// instance B uses RD_LAT=2/WR_LAT=3 for the reset-during-write case. Expected
// completions are pushed to a scoreboard queue when an access is driven and
// popped when the DUT drops busy.
// -----------------------------------------------------------------------------
module tb_sobel_mem_responder;

  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 8;
  localparam int DEPTH    = 4096;
  localparam int RD_LAT   = 2;
  localparam int WR_LAT_A = 1;
  localparam int WR_LAT_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sobel_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_a ();
  sobel_mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus_b ();

  sobel_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .RD_LAT(RD_LAT), .WR_LAT(WR_LAT_A)
  ) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.slave)
  );

  sobel_mem_responder #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH),
    .RD_LAT(RD_LAT), .WR_LAT(WR_LAT_B)
  ) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.slave)
  );

  typedef struct {
    string      tag;
    int         lat;
    logic [7:0] data;
    logic       err;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] model  [2][DEPTH];
  logic [7:0] exp_dr [2];
  int         n_checks = 0;
  int         n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic [1:0] ins, input logic [15:0] ar,
                       input logic [15:0] aw, input logic [7:0] dw);
    if (sel == 1'b0) begin
      bus_a.instruction = ins; bus_a.addr_r = ar; bus_a.addr_w = aw; bus_a.data_w = dw;
    end else begin
      bus_b.instruction = ins; bus_b.addr_r = ar; bus_b.addr_w = aw; bus_b.data_w = dw;
    end
  endtask

  task automatic set_ins(input bit sel, input logic [1:0] ins);
    if (sel == 1'b0) bus_a.instruction = ins;
    else             bus_b.instruction = ins;
  endtask

  function automatic logic busy_of(input bit sel);
    return (sel == 1'b0) ? bus_a.busy : bus_b.busy;
  endfunction

  function automatic logic err_of(input bit sel);
    return (sel == 1'b0) ? bus_a.err : bus_b.err;
  endfunction

  function automatic logic [7:0] dr_of(input bit sel);
    return (sel == 1'b0) ? bus_a.data_r : bus_b.data_r;
  endfunction

  // Builds the expected completion from the bench model and queues it.
  task automatic predict(input bit sel, input logic [1:0] ins, input logic [15:0] adr,
                         input logic [7:0] dw, input string tag);
    exp_t e;
    e.tag = tag; e.err = 1'b0; e.lat = 1;
    case (ins)
      2'b01: begin
        e.lat = RD_LAT;
        if (adr < DEPTH) exp_dr[sel] = model[sel][adr];
        else begin exp_dr[sel] = 8'h00; e.err = 1'b1; end
      end
      2'b10: begin
        e.lat = (sel == 1'b0) ? WR_LAT_A : WR_LAT_B;
        if (adr < DEPTH) model[sel][adr] = dw;
        else e.err = 1'b1;
      end
      default: e.err = 1'b1;
    endcase
    e.data = exp_dr[sel];
    sb.push_back(e);
  endtask

  // Counts busy cycles after an acceptance edge and compares the completion.
  // Called at the negedge right after the acceptance posedge.
  task automatic complete(input bit sel, input bit intrude, input logic [15:0] adr,
                          input bit drop_at_end);
    exp_t e;
    int   n = 0;
    while (busy_of(sel) === 1'b1 && n < 20) begin
      n++;
      check({"err_while_busy"}, {31'd0, err_of(sel)}, 32'd0);
      if (intrude && n == 1) drive(sel, 2'b10, adr + 16'd1, adr, 8'h77);
      else if (drop_at_end == 1'b0) set_ins(sel, 2'b00);
      @(negedge clk);
    end
    if (drop_at_end) set_ins(sel, 2'b00);
    e = sb.pop_front();
    check({e.tag, "_busy_cycles"}, n, e.lat);
    check({e.tag, "_data_r"}, {24'd0, dr_of(sel)}, {24'd0, e.data});
    check({e.tag, "_err"}, {31'd0, err_of(sel)}, {31'd0, e.err});
  endtask

  // Single access from an idle negedge; ends on the negedge after completion,
  // also confirming err lasted only one cycle.
  task automatic access(input bit sel, input logic [1:0] ins, input logic [15:0] adr,
                        input logic [7:0] dw, input bit intrude, input string tag);
    check({tag, "_idle_before"}, {31'd0, busy_of(sel)}, 32'd0);
    predict(sel, ins, adr, dw, tag);
    drive(sel, ins, adr, adr, dw);
    @(posedge clk);
    @(negedge clk);
    complete(sel, intrude, adr, 1'b0);
    @(negedge clk);
    check({tag, "_err_single"}, {31'd0, err_of(sel)}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "timeout");
  end

  initial begin
    drive(1'b0, 2'b00, 16'd0, 16'd0, 8'd0);
    drive(1'b1, 2'b00, 16'd0, 16'd0, 8'd0);
    exp_dr[0] = 8'h00;
    exp_dr[1] = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int s = 0; s < 2; s++) begin
      check("reset_busy",   {31'd0, busy_of(s[0])}, 32'd0);
      check("reset_data_r", {24'd0, dr_of(s[0])},   32'd0);
      check("reset_err",    {31'd0, err_of(s[0])},  32'd0);
    end

    // Write then read back.
    access(1'b0, 2'b10, 16'd12, 8'hA5, 1'b0, "wr12");
    access(1'b0, 2'b01, 16'd12, 8'h00, 1'b0, "rd12");

    // Known contents for addresses 0..3.
    for (int k = 0; k < 4; k++) access(1'b0, 2'b10, 16'(k), 8'h10 + 8'(k), 1'b0, "wr_prep");

    // Write presented while busy is dropped; address changes mid-flight ignored.
    access(1'b0, 2'b01, 16'd3, 8'h00, 1'b1, "rd3_busy");
    access(1'b0, 2'b01, 16'd3, 8'h00, 1'b0, "rd3_again");

    // Out of range read/write at the DEPTH boundary and beyond.
    access(1'b0, 2'b01, 16'd4096, 8'h00, 1'b0, "rd_oor");
    access(1'b0, 2'b10, 16'd904,  8'h21, 1'b0, "wr904");
    access(1'b0, 2'b10, 16'd5000, 8'hEE, 1'b0, "wr_oor");
    access(1'b0, 2'b01, 16'd904,  8'h00, 1'b0, "rd904");
    access(1'b0, 2'b01, 16'd4095, 8'h00, 1'b0, "rd4095_prep_wr");

    // Illegal instruction.
    access(1'b0, 2'b10, 16'd4095, 8'h5C, 1'b0, "wr4095");
    access(1'b0, 2'b01, 16'd4095, 8'h00, 1'b0, "rd4095");
    access(1'b0, 2'b11, 16'd0,    8'h00, 1'b0, "illegal");

    // Back-to-back reads with instruction held at 01.
    for (int k = 0; k < 4; k++) begin
      predict(1'b0, 2'b01, 16'(k), 8'h00, "b2b");
      drive(1'b0, 2'b01, 16'(k), 16'd0, 8'h00);
      @(posedge clk);
      @(negedge clk);
      complete(1'b0, 1'b0, 16'(k), (k == 3));
    end
    @(negedge clk);

    // Reset during a write on instance B.
    access(1'b1, 2'b10, 16'd7, 8'h11, 1'b0, "b_wr7");
    access(1'b1, 2'b01, 16'd7, 8'h00, 1'b0, "b_rd7");
    drive(1'b1, 2'b10, 16'd7, 16'd7, 8'h3C);
    @(posedge clk);
    @(negedge clk);
    set_ins(1'b1, 2'b00);
    check("b_rst_busy_c1", {31'd0, bus_b.busy}, 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("b_rst_busy_c2", {31'd0, bus_b.busy}, 32'd1);
    rst = 1'b1;
    drive(1'b1, 2'b01, 16'd7, 16'd0, 8'h00);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    set_ins(1'b1, 2'b00);
    exp_dr[0] = 8'h00;
    exp_dr[1] = 8'h00;
    check("b_rst_busy",   {31'd0, bus_b.busy},   32'd0);
    check("b_rst_data_r", {24'd0, bus_b.data_r}, 32'd0);
    check("b_rst_err",    {31'd0, bus_b.err},    32'd0);
    repeat (4) @(negedge clk);
    check("b_rst_no_late_done", {31'd0, bus_b.busy}, 32'd0);
    access(1'b1, 2'b01, 16'd7, 8'h00, 1'b0, "b_rd7_after_rst");

    check("sb_empty", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sobel_mem_responder.md
# sobel_mem_responder

Memory-side responder for the Sobel pipeline's read/write controller. It decodes the controller's instruction/address/data bundle, holds `busy` for a fixed parameterised latency, then completes the access against an internal pixel RAM. It returns read data on `data_r` and reports out-of-range or illegal requests on `err`. It stands in for the image SRAM, both in the system and as the bench target for the controller.

## Interface
- `ADDR_W`, 16, address width of `addr_r`/`addr_w`.
- `DATA_W`, 8, pixel width.
- `DEPTH`, 4096, number of RAM words; legal addresses are 0..DEPTH-1.
- `RD_LAT`, 2, busy cycles per read; must be ≥1.
- `WR_LAT`, 1, busy cycles per write; must be ≥1.

Ports (name, direction, width, meaning):
- `clk` in 1: the single clock; all logic on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `instruction` in 2: 00 idle, 01 read, 10 write, 11 illegal.
- `addr_r` in ADDR_W: read address, sampled on acceptance.
- `addr_w` in ADDR_W: write address, sampled on acceptance.
- `data_w` in DATA_W: write data, sampled on acceptance.
- `busy` out 1: access in progress; new instructions are ignored while high.
- `data_r` out DATA_W: last completed read data, held until the next read completes.
- `err` out 1: one-cycle pulse on completion of an out-of-range or illegal access.

## Operation
- FSM states: IDLE, READ, WRITE, FAULT.
- Acceptance: at a rising edge where the registered `busy`=0, `rst`=0 and `instruction`≠00.
  - `addr_r`, `addr_w` and `data_w` are captured into internal registers.
  - Latency counter loads the access latency minus 1.
  - State moves from IDLE to READ (01), WRITE (10) or FAULT (11).
- Read, WRITE and FAULT states: counter decrements each cycle. When counter = 0, the next edge completes the access and returns to IDLE.
- Read completion:
  - In range: `data_r` ← mem[captured addr_r].
  - Out of range (addr ≥ DEPTH): `data_r` ← 0 and `err` pulses.
- Write completion:
  - In range: mem[captured addr_w] ← captured `data_w`.
  - Out of range: no memory update and `err` pulses.
- FAULT: fixed 1-cycle busy, no memory access, `data_r` unchanged, `err` pulses at completion.
- Instructions presented while `busy`=1 are dropped, not queued. The controller must re-present after `busy` falls.
- `instruction` held at a non-idle value across completion: a new access is accepted at the first edge where `busy`=0. There is therefore one idle cycle between back-to-back accesses.
- Address/data changes after acceptance have no effect on the in-flight access.
- Memory is not initialised by reset. Contents survive `rst`.

## Timing
- Reset values: `busy`=0, `data_r`=0, `err`=0, state IDLE, counter 0.
- Acceptance at edge E0:
  - `busy`=1 from just after E0 through edge E0+L, where L = RD_LAT, WR_LAT, or 1 for illegal.
  - At edge E0+L: `busy`←0, `data_r` updated (reads), memory written (writes), and `err` asserted for one cycle if applicable.
- Read latency from acceptance edge to valid `data_r` is exactly RD_LAT cycles. `data_r` and the `busy` fall are coincident.
- Earliest next acceptance is edge E0+L+1.
- `rst` high at any edge dominates everything:
  - In-flight access is aborted and a pending write is discarded.
  - `busy`/`err`/`data_r` are forced to 0.
  - An instruction presented in the same cycle is ignored.
- `err` is never high for more than one consecutive cycle. It is 0 whenever `busy`=1.

## Test plan
- Write then read, RD_LAT=2, WR_LAT=1:
  - write 8'hA5 to addr 12, then read addr 12.
  - Expected: `busy` high for 1 then 2 cycles; `data_r`=A5 on the edge `busy` falls; `err`=0 throughout.
- Busy rejection: issue a read of addr 3, then a write to addr 3 while `busy`=1 → write has no effect; a later read of addr 3 returns the old value.
- Out of range, DEPTH=4096: read addr 4096 → `data_r`=0, `err` 1-cycle pulse at completion; write to addr 5000 → `err` pulse, no memory change.
- Illegal instruction 11 → `busy` high exactly 1 cycle, `err` pulse, `data_r` unchanged.
- Reset mid-write: accept a write of 8'h3C to addr 7 with WR_LAT=3, assert `rst` on the second busy cycle → `busy`=0 next edge; a read of addr 7 returns the pre-write value.
- Back-to-back: hold `instruction`=01 continuously over addrs 0..3 → one idle cycle between accesses, each `data_r` matches the RAM contents.
